pipeif: RTL and testbench
=========================

# pipeif

Instruction-fetch stage of the five-stage pipelined CPU. It sits directly upstream of the IF/ID pipeline register and drives that register's `pc4`, `ins` and `jwait` inputs. It owns the PC, applies next-PC redirects from the ID stage, and runs a variable-latency request/ready handshake with instruction memory. When the ID stage is stalled, it buffers a returned instruction. When a redirect arrives while a fetch is in flight, it discards the wrong-path word.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `clock`  in  1  rising-edge clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `wpcir`  in  1  ID stall. 1 = IF/ID must hold its contents.
- `pcsource`  in  2  next-PC select from ID. 00 = pc+4, 01 = bpc, 10 = rpc, 11 = jpc.
- `bpc`, `rpc`, `jpc`  in  32 each  branch, register-jump and jump targets.
- `imem_rdata`  in  32  instruction word, valid when `imem_ready`=1.
- `imem_ready`  in  1  memory completes the current request this cycle.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address; always equals `pc`.
- `pc`  out  32  current fetch PC.
- `pc4`  out  32  `pc` + 4, to IF/ID.
- `ins`  out  32  instruction to IF/ID.
- `jwait`  out  1  flush IF/ID (insert bubble) this edge.

## Operation
- Redirect is valid when `pcsource` != 00 and `wpcir`=0. While `wpcir`=1 the ID instruction is stalled, so its `pcsource` is ignored.
- Target selection: `tgt` = `bpc`, `rpc` or `jpc` per `pcsource`. There is no delay slot: on a redirect the instruction currently in IF is wrong-path.
- `jwait` = !`wpcir` AND (redirect OR no valid instruction delivered this cycle).
  - `jwait` is never 1 while `wpcir`=1, because IF/ID gives flush priority over hold and would otherwise kill the stalled instruction.
- `pc4` is computed modulo 2^32; 32'hFFFF_FFFC + 4 = 0. Targets are used as given, with no alignment check.
- FSM states:
  - **IDLE**: the single cycle after reset. `imem_req`=0, `ins`=0. Always goes to WAIT.
  - **WAIT**: `imem_req`=1. `ins` = `imem_rdata`.
    - ready and redirect: word dropped, `jwait`=1, `pc` <= `tgt`, stay in WAIT.
    - ready, no redirect, `wpcir`=0: word delivered, `jwait`=0, `pc` <= `pc`+4, stay in WAIT.
    - ready and `wpcir`=1: `ibuf` <= `imem_rdata`, go to HELD. `pc` is unchanged.
    - not ready and redirect: `pend` <= `tgt`, go to DISCARD, `jwait`=1.
    - not ready, no redirect: `jwait` = !`wpcir`, `ins`=0.
  - **HELD**: `imem_req`=0. `ins` = `ibuf`.
    - redirect: `jwait`=1, `pc` <= `tgt`, go to WAIT.
    - else if `wpcir`=0: `ibuf` delivered, `jwait`=0, `pc` <= `pc`+4, go to WAIT.
    - else: stay in HELD.
  - **DISCARD**: `imem_req`=1 with the old `pc` held stable. `ins`=0. `jwait` = !`wpcir`. `pcsource` is ignored, since ID holds a bubble.
    - on `imem_ready`: `pc` <= `pend`, go to WAIT.

## Timing
- Reset (asynchronous, applies mid-operation too): state=IDLE, `pc`=`RESET_PC`, `ibuf`=0, `pend`=0.
- Output values during reset: `imem_req`=0, `ins`=0, `pc4`=`RESET_PC`+4, `jwait`=!`wpcir`.
- An outstanding memory request is abandoned on reset. Memory must tolerate this.
- Memory rule: once `imem_req`=1, `imem_addr` is stable until the cycle in which `imem_ready`=1. The address may change on the following edge.
- Zero-wait memory (`imem_ready` tied to 1) sustains 1 instruction per cycle.
- Latency: address presented in cycle n, ready in cycle n+k. The word reaches IF/ID at the edge ending cycle n+k.
- Redirect penalty: 1 bubble with a ready memory. With an in-flight request: the remaining wait cycles plus 1.
- `pc4`, `ins` and `jwait` are combinational from state and inputs. `pc`, `ibuf`, `pend` and state are registered.

## Structure
- Shared package `pipe_pkg` holds:
  - `pcsource` encodings: `PCS_SEQ`, `PCS_BR`, `PCS_JR`, `PCS_J`.
  - fetch state enum: IDLE, WAIT, HELD, DISCARD.
  - `NOP_INS` = 32'h0.
- One sub-module: `pipepc`, the 32-bit PC register with async reset to `RESET_PC` and a load enable. The FSM, target mux and `ibuf`/`pend` live in `pipeif`.

## Test plan
- Reset with `RESET_PC`=0, ready=1, `pcsource`=00, `wpcir`=0 -> IDLE cycle with `jwait`=1. Then `imem_addr` 0, 4, 8, …; `ins` equals the memory words; `jwait`=0.
- 2-wait-state memory at `pc`=0x10 -> `imem_addr`=0x10 for 3 cycles, `jwait`=1 for 2 cycles. The word is delivered in cycle 3, then the address becomes 0x14.
- Ready with `wpcir`=1 for 3 cycles at `pc`=0x20 -> HELD, `imem_req`=0, `ins` stable at the buffered word, `jwait`=0. After `wpcir` drops, the word is delivered and the address becomes 0x24.
- `pcsource`=01, `bpc`=0x100, ready=1 -> `jwait`=1 that cycle, `imem_addr`=0x100 next cycle. Repeat with `wpcir`=1 -> redirect ignored, `jwait`=0.
- `pcsource`=11, `jpc`=0x40 while the fetch at 0x8 is pending -> address stays 0x8 until ready, the returned word is dropped (`jwait`=1), then `imem_addr`=0x40.
- `resetn` pulse while in HELD -> `pc`=`RESET_PC`, `imem_req`=0, `ins`=0 immediately. Normal fetch resumes after the IDLE cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the pipelined CPU front end.
//   - pcsource encodings used by the ID stage to select the next PC
//   - instruction-fetch state enumeration
//   - the bubble instruction word and a PC increment helper
package pipe_pkg;

  localparam logic [1:0] PCS_SEQ = 2'b00;  // pc + 4
  localparam logic [1:0] PCS_BR  = 2'b01;  // branch target
  localparam logic [1:0] PCS_JR  = 2'b10;  // register-jump target
  localparam logic [1:0] PCS_J   = 2'b11;  // jump target

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HELD,
    DISCARD
  } fetch_state_t;

  localparam logic [31:0] NOP_INS = 32'h0000_0000;

  // Sequential PC, wrapping modulo 2^32.
  function automatic logic [31:0] pc_plus4(input logic [31:0] p);
    return p + 32'd4;
  endfunction

endpackage

// File: rtl/pipepc.sv
// pipepc: 32-bit program counter register.
//   clock   in   rising-edge clock
//   resetn  in   asynchronous active-low reset, loads RESET_PC
//   i_load  in   load enable
//   i_d     in   next PC value
//   o_q     out  current PC
module pipepc
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        i_load,
  input  logic [31:0] i_d,
  output logic [31:0] o_q
);

  logic [31:0] r_pc;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= i_d;
    end
  end

  assign o_q = r_pc;

endmodule

// File: rtl/pipeif.sv
// pipeif: instruction-fetch stage feeding the IF/ID pipeline register.
// Owns the PC, applies ID-stage redirects, and runs a request/ready
// handshake with instruction memory of arbitrary latency.
//   clock, resetn          clock and asynchronous active-low reset
//   wpcir                  ID stall (IF/ID holds)
//   pcsource, bpc/rpc/jpc  next-PC select and redirect targets
//   imem_rdata/imem_ready  memory response
//   imem_req/imem_addr     memory request (address == pc)
//   pc, pc4, ins, jwait    fetch PC and IF/ID inputs (jwait = flush)
module pipeif
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        wpcir,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic [31:0] ins,
  output logic        jwait
);

  fetch_state_t r_state;
  logic [31:0]  r_ibuf;
  logic [31:0]  r_pend;

  logic [31:0]  w_pc;
  logic [31:0]  w_pc4;
  logic [31:0]  w_tgt;
  logic         w_redirect;
  logic         w_pc_load;
  logic [31:0]  w_pc_d;
  logic         w_req;
  logic [31:0]  w_ins;
  logic         w_jwait;

  pipepc #(.RESET_PC(RESET_PC)) u_pc (
    .clock  (clock),
    .resetn (resetn),
    .i_load (w_pc_load),
    .i_d    (w_pc_d),
    .o_q    (w_pc)
  );

  assign w_pc4 = pc_plus4(w_pc);

  // A stalled ID instruction has not resolved yet, so its pcsource is
  // not acted upon until the stall releases.
  assign w_redirect = (pcsource != PCS_SEQ) && !wpcir;

  always_comb begin
    w_tgt = jpc;
    case (pcsource)
      PCS_BR:  w_tgt = bpc;
      PCS_JR:  w_tgt = rpc;
      PCS_J:   w_tgt = jpc;
      default: w_tgt = jpc;
    endcase
  end

  // Outputs and PC update. jwait is never raised while wpcir=1 because
  // IF/ID would let the flush win and kill the stalled instruction.
  always_comb begin
    w_req     = 1'b0;
    w_ins     = NOP_INS;
    w_jwait   = !wpcir;
    w_pc_load = 1'b0;
    w_pc_d    = w_pc4;
    case (r_state)
      IDLE: begin
      end
      WAIT: begin
        w_req   = 1'b1;
        w_ins   = imem_ready ? imem_rdata : NOP_INS;
        w_jwait = !wpcir && (w_redirect || !imem_ready);
        if (imem_ready) begin
          if (w_redirect) begin
            w_pc_load = 1'b1;
            w_pc_d    = w_tgt;
          end else if (!wpcir) begin
            w_pc_load = 1'b1;
          end
        end
      end
      HELD: begin
        w_ins   = r_ibuf;
        w_jwait = w_redirect;
        if (w_redirect) begin
          w_pc_load = 1'b1;
          w_pc_d    = w_tgt;
        end else if (!wpcir) begin
          w_pc_load = 1'b1;
        end
      end
      DISCARD: begin
        // The old address must stay stable until memory completes; the
        // redirect target waits in r_pend and the returned word is dropped.
        w_req = 1'b1;
        if (imem_ready) begin
          w_pc_load = 1'b1;
          w_pc_d    = r_pend;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_ibuf  <= NOP_INS;
      r_pend  <= 32'h0;
    end else begin
      case (r_state)
        IDLE: r_state <= WAIT;
        WAIT: begin
          if (imem_ready && wpcir) begin
            r_ibuf  <= imem_rdata;
            r_state <= HELD;
          end else if (!imem_ready && w_redirect) begin
            r_pend  <= w_tgt;
            r_state <= DISCARD;
          end
        end
        HELD: begin
          // Any redirect implies wpcir=0, so both exits return to WAIT.
          if (!wpcir) begin
            r_state <= WAIT;
          end
        end
        DISCARD: begin
          if (imem_ready) begin
            r_state <= WAIT;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign imem_req  = w_req;
  assign imem_addr = w_pc;
  assign pc        = w_pc;
  assign pc4       = w_pc4;
  assign ins       = w_ins;
  assign jwait     = w_jwait;

endmodule

// File: tb/tb_pipeif.sv
module tb_pipeif;

  logic        clock;
  logic        resetn;
  logic        wpcir;
  logic [1:0]  pcsource;
  logic [31:0] bpc, rpc, jpc;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc, pc4, ins;
  logic        jwait;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] exp_q[$];  // {pc4, ins} of each expected delivery

  pipeif #(.RESET_PC(32'h0000_0000)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .wpcir      (wpcir),
    .pcsource   (pcsource),
    .bpc        (bpc),
    .rpc        (rpc),
    .jpc        (jpc),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .pc         (pc),
    .pc4        (pc4),
    .ins        (ins),
    .jwait      (jwait)
  );

  // Memory word is a recognisable function of the address.
  assign imem_rdata = {16'hC0DE, imem_addr[15:0]};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: act=%08h req=%08h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: IF/ID captures an instruction when neither flushed nor held.
  always @(negedge clock) begin
    if (resetn && !jwait && !wpcir) begin
      logic [63:0] e;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_delivery: act=%08h_%08h req=none t=%0t", pc4, ins, $time);
      end else begin
        e = exp_q.pop_front();
        $display("[TB] deliver pc4=%08h ins=%08h", pc4, ins);
        check("deliver_pc4", pc4, e[63:32]);
        check("deliver_ins", ins, e[31:0]);
      end
    end
  end

  // One cycle: drive inputs after the edge, then check combinational outputs.
  // e_ins of all-X means the value is not checked.
  task automatic cyc(input logic rdy, input logic st, input logic [1:0] pcs,
                     input logic [31:0] tgt, input logic [31:0] e_addr,
                     input logic e_req, input logic e_jw, input logic [31:0] e_ins,
                     input logic dlv);
    @(posedge clock);
    #1;
    imem_ready = rdy;
    wpcir      = st;
    pcsource   = pcs;
    bpc = (pcs == 2'b01) ? tgt : 32'hBAD0_0001;
    rpc = (pcs == 2'b10) ? tgt : 32'hBAD0_0002;
    jpc = (pcs == 2'b11) ? tgt : 32'hBAD0_0003;
    #2;
    check("imem_addr", imem_addr, e_addr);
    check("pc", pc, e_addr);
    check("imem_req", {31'd0, imem_req}, {31'd0, e_req});
    check("jwait", {31'd0, jwait}, {31'd0, e_jw});
    if (!$isunknown(e_ins)) check("ins", ins, e_ins);
    if (dlv) exp_q.push_back({e_addr + 32'd4, e_ins});
  endtask

  localparam logic [31:0] XX = 32'hxxxx_xxxx;

  initial begin
    resetn = 1'b0; wpcir = 1'b0; pcsource = 2'b00;
    bpc = 0; rpc = 0; jpc = 0; imem_ready = 1'b1;
    #3;
    check("rst_pc", pc, 32'h0);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_ins", ins, 32'h0);
    check("rst_pc4", pc4, 32'h4);
    check("rst_jwait", {31'd0, jwait}, 32'd1);
    wpcir = 1'b1;
    #1;
    check("rst_jwait_stall", {31'd0, jwait}, 32'd0);
    wpcir = 1'b0;
    @(posedge clock);
    #1 resetn = 1'b1;
    #2;
    check("idle_req", {31'd0, imem_req}, 32'd0);
    check("idle_jwait", {31'd0, jwait}, 32'd1);
    check("idle_ins", ins, 32'h0);

    //  rdy  st  pcs   tgt           addr          req jw  ins            dlv
    // zero-wait streaming
    cyc(1, 0, 2'b00, 0,            32'h0000_0000, 1, 0, 32'hC0DE_0000, 1);
    cyc(1, 0, 2'b00, 0,            32'h0000_0004, 1, 0, 32'hC0DE_0004, 1);
    cyc(1, 0, 2'b00, 0,            32'h0000_0008, 1, 0, 32'hC0DE_0008, 1);
    cyc(1, 0, 2'b00, 0,            32'h0000_000C, 1, 0, 32'hC0DE_000C, 1);
    // two wait states at 0x10
    cyc(0, 0, 2'b00, 0,            32'h0000_0010, 1, 1, 32'h0000_0000, 0);
    cyc(0, 0, 2'b00, 0,            32'h0000_0010, 1, 1, 32'h0000_0000, 0);
    cyc(1, 0, 2'b00, 0,            32'h0000_0010, 1, 0, 32'hC0DE_0010, 1);
    cyc(1, 0, 2'b00, 0,            32'h0000_0014, 1, 0, 32'hC0DE_0014, 1);
    cyc(1, 0, 2'b00, 0,            32'h0000_0018, 1, 0, 32'hC0DE_0018, 1);
    cyc(1, 0, 2'b00, 0,            32'h0000_001C, 1, 0, 32'hC0DE_001C, 1);
    // stall with ready at 0x20 -> HELD for three cycles, then delivered
    cyc(1, 1, 2'b00, 0,            32'h0000_0020, 1, 0, 32'hC0DE_0020, 0);
    cyc(1, 1, 2'b00, 0,            32'h0000_0020, 0, 0, 32'hC0DE_0020, 0);
    cyc(1, 1, 2'b00, 0,            32'h0000_0020, 0, 0, 32'hC0DE_0020, 0);
    cyc(1, 0, 2'b00, 0,            32'h0000_0020, 0, 0, 32'hC0DE_0020, 1);
    // branch redirect with ready memory: one bubble
    cyc(1, 0, 2'b01, 32'h100,      32'h0000_0024, 1, 1, 32'hC0DE_0024, 0);
    cyc(1, 0, 2'b00, 0,            32'h0000_0100, 1, 0, 32'hC0DE_0100, 1);
    // branch while stalled is ignored
    cyc(1, 1, 2'b01, 32'h100,      32'h0000_0104, 1, 0, 32'hC0DE_0104, 0);
    cyc(1, 0, 2'b00, 0,            32'h0000_0104, 0, 0, 32'hC0DE_0104, 1);
    // register-jump redirect taken out of HELD
    cyc(1, 1, 2'b00, 0,            32'h0000_0108, 1, 0, 32'hC0DE_0108, 0);
    cyc(1, 0, 2'b10, 32'h200,      32'h0000_0108, 0, 1, 32'hC0DE_0108, 0);
    cyc(1, 0, 2'b00, 0,            32'h0000_0200, 1, 0, 32'hC0DE_0200, 1);
    // jump while fetch at 0x8 pending: word dropped, then 0x40
    cyc(1, 0, 2'b01, 32'h8,        32'h0000_0204, 1, 1, 32'hC0DE_0204, 0);
    cyc(0, 0, 2'b11, 32'h40,       32'h0000_0008, 1, 1, XX,            0);
    cyc(0, 1, 2'b11, 32'h80,       32'h0000_0008, 1, 0, 32'h0000_0000, 0);
    cyc(1, 0, 2'b00, 0,            32'h0000_0008, 1, 1, 32'h0000_0000, 0);
    cyc(1, 0, 2'b00, 0,            32'h0000_0040, 1, 0, 32'hC0DE_0040, 1);
    // pc4 wraps at the top of the address space
    cyc(1, 0, 2'b11, 32'hFFFF_FFFC, 32'h0000_0044, 1, 1, 32'hC0DE_0044, 0);
    cyc(1, 0, 2'b00, 0,            32'hFFFF_FFFC, 1, 0, 32'hC0DE_FFFC, 1);
    cyc(1, 0, 2'b00, 0,            32'h0000_0000, 1, 0, 32'hC0DE_0000, 1);
    // enter HELD, then reset mid-cycle
    cyc(1, 1, 2'b00, 0,            32'h0000_0004, 1, 0, 32'hC0DE_0004, 0);
    cyc(1, 1, 2'b00, 0,            32'h0000_0004, 0, 0, 32'hC0DE_0004, 0);
    resetn = 1'b0;
    #1;
    check("midrst_pc", pc, 32'h0);
    check("midrst_req", {31'd0, imem_req}, 32'd0);
    check("midrst_ins", ins, 32'h0);
    check("midrst_pc4", pc4, 32'h4);
    check("midrst_jwait_stall", {31'd0, jwait}, 32'd0);
    wpcir = 1'b0;
    #1;
    check("midrst_jwait", {31'd0, jwait}, 32'd1);
    @(posedge clock);
    #1 resetn = 1'b1;
    #2;
    check("midrst_idle_req", {31'd0, imem_req}, 32'd0);
    check("midrst_idle_jwait", {31'd0, jwait}, 32'd1);
    cyc(1, 0, 2'b00, 0,            32'h0000_0000, 1, 0, 32'hC0DE_0000, 1);
    cyc(1, 0, 2'b00, 0,            32'h0000_0004, 1, 0, 32'hC0DE_0004, 1);

    @(posedge clock);
    #1 wpcir = 1'b1;
    @(negedge clock);
    #1;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
